// File: rtl/param_add_if.sv
// Operand-load / start-busy-done bundle between the LA probe decode and param_add_engine.
// Handshake: start is taken only when busy=0 and done=0; done pulses one cycle with the new result.
interface param_add_if #(
  parameter int WIDTH   = 8,
  parameter int CHUNK_W = 4
);
  logic               load_en;
  logic               load_sel;
  logic [CHUNK_W-1:0] load_data;
  logic               start;
  logic               sub;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   sum;
  logic               carry;
  logic               overflow;
  logic [1:0]         dbg_state;

  modport master (
    output load_en, load_sel, load_data, start, sub,
    input  busy, done, sum, carry, overflow, dbg_state
  );

  modport slave (
    input  load_en, load_sel, load_data, start, sub,
    output busy, done, sum, carry, overflow, dbg_state
  );
endinterface

// File: rtl/param_add_engine.sv
// Chunk-loaded add/subtract engine with a programmable busy period and done pulse.
// Optional: define ADD_SAT_EN for unsigned saturation of the result.
module param_add_engine #(
  parameter int WIDTH   = 8,
  parameter int CHUNK_W = 4,
  parameter int DELAY   = 1023
) (
  input  logic        clk,
  input  logic        reset_n,
  param_add_if.slave  bus
);

  localparam int CNT_W = (DELAY < 2) ? 1 : $clog2(DELAY + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DELAY);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_a, r_b;
  logic [WIDTH-1:0] w_a_shift, w_b_shift;
  logic [WIDTH-1:0] r_wa, r_wb;
  logic             r_wsub;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry, r_ovf;
  logic             w_busy, w_done;
  logic             w_accept, w_last;
  logic [WIDTH-1:0] w_bop;
  logic [WIDTH:0]   w_full;
  logic             w_ovf;
  logic [WIDTH-1:0] w_sum_fin;

  generate
    if (WIDTH == CHUNK_W) begin : g_single_chunk
      assign w_a_shift = bus.load_data;
      assign w_b_shift = bus.load_data;
    end else begin : g_multi_chunk
      assign w_a_shift = {r_a[WIDTH-CHUNK_W-1:0], bus.load_data};
      assign w_b_shift = {r_b[WIDTH-CHUNK_W-1:0], bus.load_data};
    end
  endgenerate

  assign w_accept = (r_state == S_IDLE) && bus.start;
  assign w_last   = (r_state == S_BUSY) && (r_cnt == CNT_LAST);

  // Shadow operands accept loads in every state; the working copy is frozen at start.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_a <= '0;
      r_b <= '0;
    end else if (bus.load_en) begin
      if (bus.load_sel) r_b <= w_b_shift;
      else              r_a <= w_a_shift;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wa   <= '0;
      r_wb   <= '0;
      r_wsub <= 1'b0;
    end else if (w_accept) begin
      r_wa   <= r_a;
      r_wb   <= r_b;
      r_wsub <= bus.sub;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (r_state != S_BUSY) begin
      r_cnt <= '0;
    end else if (r_cnt != CNT_LAST) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = S_IDLE;
    case (r_state)
      S_IDLE:  w_state_nxt = bus.start ? S_BUSY : S_IDLE;
      S_BUSY:  w_state_nxt = (r_cnt == CNT_LAST) ? S_DONE : S_BUSY;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      S_BUSY:  w_busy = 1'b1;
      S_DONE:  w_done = 1'b1;
      default: ;
    endcase
  end

  // Subtract is A + ~B + 1, so carry=1 means no borrow.
  assign w_bop  = r_wsub ? ~r_wb : r_wb;
  assign w_full = {1'b0, r_wa} + {1'b0, w_bop} + {{WIDTH{1'b0}}, r_wsub};
  assign w_ovf  = (r_wa[WIDTH-1] == w_bop[WIDTH-1]) && (w_full[WIDTH-1] != r_wa[WIDTH-1]);

`ifdef ADD_SAT_EN
  always_comb begin
    w_sum_fin = w_full[WIDTH-1:0];
    if (!r_wsub && w_full[WIDTH])     w_sum_fin = '1;
    else if (r_wsub && !w_full[WIDTH]) w_sum_fin = '0;
  end
`else
  assign w_sum_fin = w_full[WIDTH-1:0];
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_last) begin
      r_sum   <= w_sum_fin;
      r_carry <= w_full[WIDTH];
      r_ovf   <= w_ovf;
    end
  end

  assign bus.busy      = w_busy;
  assign bus.done      = w_done;
  assign bus.sum       = r_sum;
  assign bus.carry     = r_carry;
  assign bus.overflow  = r_ovf;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_param_add_engine.sv
// Randomized and directed bench for param_add_engine (WIDTH=8, CHUNK_W=4, DELAY=3).
module tb_param_add_engine;

  localparam int WIDTH   = 8;
  localparam int CHUNK_W = 4;
  localparam int DELAY   = 3;
  localparam int NCH     = WIDTH / CHUNK_W;
  localparam int RW      = WIDTH + 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk = ~clk;

  param_add_if #(.WIDTH(WIDTH), .CHUNK_W(CHUNK_W)) bus ();

  param_add_engine #(.WIDTH(WIDTH), .CHUNK_W(CHUNK_W), .DELAY(DELAY)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [WIDTH-1:0] sh_a, sh_b;
  logic [RW-1:0]    last_res;
  logic [RW-1:0]    exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic, packed as {overflow, carry, sum}.
  function automatic logic [RW-1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                          input logic s);
    int full, half, ai, bi, sa, sb, r, sr;
    logic c, o;
    logic [WIDTH-1:0] sv;
    full = 1 << WIDTH;
    half = full / 2;
    ai = int'(a);
    bi = int'(b);
    sa = (ai >= half) ? ai - full : ai;
    sb = (bi >= half) ? bi - full : bi;
    if (!s) begin
      r  = ai + bi;
      c  = (r >= full);
      sr = sa + sb;
    end else begin
      r  = ai - bi;
      c  = (ai >= bi);
      sr = sa - sb;
    end
    r  = ((r % full) + full) % full;
    sv = r[WIDTH-1:0];
    o  = (sr > half - 1) || (sr < -half);
`ifdef ADD_SAT_EN
    if (!s && c) sv = '1;
    if (s && !c) sv = '0;
`endif
    return {o, c, sv};
  endfunction

  task automatic model_load(input logic sel, input logic [CHUNK_W-1:0] ch);
    if (sel) sh_b = (sh_b << CHUNK_W) | WIDTH'(ch);
    else     sh_a = (sh_a << CHUNK_W) | WIDTH'(ch);
  endtask

  task automatic load_val(input logic sel, input logic [WIDTH-1:0] v);
    for (int i = NCH - 1; i >= 0; i--) begin
      @(negedge clk);
      bus.load_en   = 1'b1;
      bus.load_sel  = sel;
      bus.load_data = v[i*CHUNK_W +: CHUNK_W];
      model_load(sel, v[i*CHUNK_W +: CHUNK_W]);
    end
    @(negedge clk);
    bus.load_en = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    sh_a = '0;
    sh_b = '0;
    last_res = '0;
    exp_q.delete();
  endtask

  // mode 0: plain; 1: load into B coincident with start; 2: load A=0xAA and re-start during BUSY
  task automatic run_op(input logic s, input int mode);
    logic [RW-1:0] e;
    logic [CHUNK_W-1:0] ch;
    @(negedge clk);
    bus.start = 1'b1;
    bus.sub   = s;
    exp_q.push_back(model(sh_a, sh_b, s));
    if (mode == 1) begin
      ch = CHUNK_W'($urandom);
      bus.load_en   = 1'b1;
      bus.load_sel  = 1'b1;
      bus.load_data = ch;
      model_load(1'b1, ch);
    end
    for (int k = 1; k <= DELAY + 6; k++) begin
      @(negedge clk);
      bus.start   = 1'b0;
      bus.load_en = 1'b0;
      check("busy", bus.busy, 32'(k <= DELAY + 1));
      check("done", bus.done, 32'(k == DELAY + 2));
      if (k <= DELAY + 1) check("hold_sum", bus.sum, last_res[WIDTH-1:0]);
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          check("extra_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("sum", bus.sum, e[WIDTH-1:0]);
          check("carry", bus.carry, e[WIDTH]);
          check("overflow", bus.overflow, e[WIDTH+1]);
          last_res = e;
        end
      end
      if (mode == 2 && (k == 1 || k == 2)) begin
        bus.load_en   = 1'b1;
        bus.load_sel  = 1'b0;
        bus.load_data = CHUNK_W'(4'hA);
        model_load(1'b0, CHUNK_W'(4'hA));
        if (k == 2) begin
          bus.start = 1'b1;
          bus.sub   = 1'b0;
        end
      end
    end
    check("pending", exp_q.size(), 0);
  endtask

  initial begin
    logic [WIDTH-1:0] ra, rb;
    bus.load_en   = 1'b0;
    bus.load_sel  = 1'b0;
    bus.load_data = '0;
    bus.start     = 1'b0;
    bus.sub       = 1'b0;
    sh_a = '0;
    sh_b = '0;
    last_res = '0;

    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_sum", bus.sum, 0);
    check("rst_carry", bus.carry, 0);
    check("rst_ovf", bus.overflow, 0);
    reset_n = 1'b1;

    // basic add via chunks 3,C and 0,5
    load_val(1'b0, 8'h3C);
    load_val(1'b1, 8'h05);
    run_op(1'b0, 0);
    check("basic_sum", bus.sum, 8'h41);

    load_val(1'b0, 8'hF0);
    load_val(1'b1, 8'h20);
    run_op(1'b0, 0);

    load_val(1'b0, 8'h05);
    load_val(1'b1, 8'h07);
    run_op(1'b1, 0);

    load_val(1'b0, 8'h7F);
    load_val(1'b1, 8'h01);
    run_op(1'b0, 0);

    // snapshot isolation, dropped start, then the second operation sees A=0xAA
    load_val(1'b0, 8'h10);
    load_val(1'b1, 8'h01);
    run_op(1'b0, 2);
    check("snap_sum", bus.sum, 8'h11);
    run_op(1'b0, 0);
    check("snap2_sum", bus.sum, 8'hAB);

    // reset mid-BUSY
    load_val(1'b0, 8'h3C);
    load_val(1'b1, 8'h05);
    run_op(1'b0, 0);
    check("pre_rst_sum", bus.sum, 8'h41);
    @(negedge clk);
    bus.start = 1'b1;
    bus.sub   = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    check("mid_busy1", bus.busy, 1);
    @(negedge clk);
    check("mid_busy2", bus.busy, 1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_sum", bus.sum, 0);
    check("abort_carry", bus.carry, 0);
    sh_a = '0;
    sh_b = '0;
    last_res = '0;
    exp_q.delete();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("abort_no_done", bus.done, 0);
      check("abort_idle", bus.busy, 0);
    end

    // randomized operations, sometimes reusing shadow values or loading at start
    for (int n = 0; n < 40; n++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      if ($urandom_range(0, 3) != 0) load_val(1'b0, ra);
      if ($urandom_range(0, 3) != 0) load_val(1'b1, rb);
      run_op(1'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
    end

    apply_reset();
    @(negedge clk);
    check("final_sum", bus.sum, 0);
    check("final_busy", bus.busy, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/param_add_engine.md
# param_add_engine

Parametrised successor of the fixed 3-bit adder engine. Accepts two WIDTH-bit operands shifted in CHUNK_W bits at a time from the logic-analyzer probe bus, then runs a programmable add/subtract operation with a configurable busy period and a start/busy/done handshake. The result is held stable until the next operation completes. It sits between the LA probe decode in the user project wrapper and the LA readback bus.

## Interface
Parameters:
- WIDTH, 8, operand and result width; must be an integer multiple of CHUNK_W, minimum 2.
- CHUNK_W, 4, bits loaded per load strobe.
- DELAY, 1023, busy-period terminal count; BUSY lasts DELAY+1 cycles; range 0..2^16-1.

Ports:
- clk  input  1  sole clock; all logic on its rising edge.
- reset_n  input  1  synchronous, active-low reset.
- load_en  input  1  one-cycle strobe: shift load_data into the selected operand.
- load_sel  input  1  0 selects operand A, 1 selects operand B.
- load_data  input  CHUNK_W  chunk to shift in.
- start  input  1  begin an operation; honoured only in IDLE.
- sub  input  1  sampled with start: 0 computes A+B, 1 computes A-B.
- busy  output  1  high while in BUSY.
- done  output  1  one-cycle pulse when the result is updated.
- sum  output  WIDTH  result register.
- carry  output  1  carry out of the adder. On subtract it is 1 when A>=B (no borrow).
- overflow  output  1  two's-complement signed overflow of the last operation.

## Operation
- Operand shadow registers A and B:
  - On load_en, the selected register takes {reg[WIDTH-CHUNK_W-1:0], load_data}, MSB chunk first.
  - When WIDTH==CHUNK_W, the register takes load_data directly.
- Loads are accepted in every state.
- On an accepted start, A, B and sub are snapshotted into working registers. Loads during BUSY/DONE therefore affect only the next operation.
- States:
  - IDLE: go to BUSY on start. The counter is held at 0.
  - BUSY: the counter increments each cycle. When counter==DELAY, register the result and go to DONE.
  - DONE: done=1 for this one cycle, then go to IDLE unconditionally. start is ignored here.
- An undefined state encoding recovers to IDLE.
- Arithmetic:
  - Compute {carry,sum} = A + (sub ? ~B : B) + sub, in WIDTH+1 bits.
  - overflow = (A[MSB] == Bop[MSB]) && (sum[MSB] != A[MSB]), where Bop is the post-inversion operand.
- The counter is sized clog2(DELAY+1), minimum 1 bit. It never wraps, because the exit compare is at DELAY.

## Timing
- Reset, applied while reset_n=0 at a clk edge:
  - state=IDLE, counter=0.
  - A, B, working registers, sum, carry and overflow = 0.
  - busy=0, done=0.
- Reset asserted mid-BUSY or mid-DONE aborts the operation. No done pulse is produced and the result is cleared.
- start sampled high in IDLE at edge t:
  - busy=1 from t+1 through t+DELAY+1.
  - done=1 and the new sum/carry/overflow are visible in cycle t+DELAY+2.
  - busy=0 in that cycle.
- Earliest next start is sampled in cycle t+DELAY+3 (back in IDLE). Total throughput is DELAY+3 cycles per operation.
- start during BUSY or DONE is dropped, not queued.
- load_en coincident with start: the start snapshot takes the pre-load operand value. The load lands in the shadow register.
- sum, carry and overflow change only on the BUSY->DONE edge or on reset.
- busy and done are registered; they are never high together.

## Configuration
- ADD_SAT_EN defined: unsigned saturation.
  - An add with carry=1 sets sum to all ones.
  - A subtract with carry=0 sets sum to 0.
  - carry and overflow still report the raw, unsaturated result.
- ADD_SAT_EN undefined: sum wraps modulo 2^WIDTH. No saturation logic is instantiated.

## Test plan
All scenarios use WIDTH=8, CHUNK_W=4, DELAY=3.
- Basic add:
  - Stimulus: load A with chunks 0x3,0xC; load B with 0x0,0x5; start with sub=0 at cycle t.
  - Response: busy in t+1..t+4; done at t+5; sum=0x41, carry=0, overflow=0.
- Add with carry out:
  - Stimulus: A=0xF0, B=0x20, add.
  - Response without ADD_SAT_EN: sum=0x10, carry=1, overflow=0. With ADD_SAT_EN: sum=0xFF, carry=1.
- Subtract with borrow:
  - Stimulus: A=0x05, B=0x07, sub=1.
  - Response without ADD_SAT_EN: sum=0xFE, carry=0. With ADD_SAT_EN: sum=0x00.
- Signed overflow:
  - Stimulus: A=0x7F, B=0x01, add.
  - Response: sum=0x80, overflow=1, carry=0.
- Snapshot isolation and dropped start:
  - Stimulus: start A=0x10, B=0x01; during BUSY load A=0xAA and pulse start.
  - Response: exactly one done with sum=0x11. A second start in IDLE then yields sum=0xAB.
- Reset mid-operation:
  - Stimulus: after a completed op with sum=0x41, start a new op and drive reset_n=0 for one cycle in the second BUSY cycle.
  - Response: busy=0, sum=0, carry=0 the next cycle; no done pulse for at least 10 cycles.
